// File: rtl/pixel_writer_pkg.sv
// Shared panel geometry, pixel word type and write-side FSM state encoding
// for the SPI-fed framebuffer writer.
package pixel_writer_pkg;

  localparam int unsigned PANEL_W = 64;
  localparam int unsigned PANEL_H = 32;
  localparam int unsigned ADDR_W  = 11;

  typedef logic [15:0] pixel_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SKIP,
    ST_RECEIVE,
    ST_SWAP
  } state_t;

endpackage

// File: rtl/pixel_writer_edge_sync.sv
// Two-flop synchroniser followed by an edge flop; flags a falling edge of an
// asynchronous input for exactly one clk cycle.
module edge_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic fall
);

  // [0],[1] synchronise, [2] holds the previous synchronised value
  logic [2:0] sync_q;
  logic [2:0] sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], async_in};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {3{RESET_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign fall = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/pixel_writer.sv
// Writes SPI pixel words into the back half of a double-buffered framebuffer
// and hands the buffer to the scanner through a swap_req/swap_ack handshake.
module pixel_writer #(
  parameter int unsigned PANEL_W = pixel_writer_pkg::PANEL_W,
  parameter int unsigned PANEL_H = pixel_writer_pkg::PANEL_H,
  parameter int unsigned ADDR_W  = pixel_writer_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pixel_clk,
  input  logic [15:0]       pixel_data,
  input  logic              spi_ss_n,
  output logic              fb_we,
  output logic [ADDR_W:0]   fb_addr,
  output logic [15:0]       fb_wdata,
  output logic              swap_req,
  input  logic              swap_ack,
  output logic              front_buffer,
  output logic              overrun
);

  import pixel_writer_pkg::*;

  localparam int unsigned NPIX = PANEL_W * PANEL_H;

  logic word_evt;
  logic frame_start;

  edge_sync #(.RESET_VAL(1'b1)) u_pix_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (pixel_clk),
    .fall     (word_evt)
  );

  edge_sync #(.RESET_VAL(1'b1)) u_ss_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (spi_ss_n),
    .fall     (frame_start)
  );

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic              fb_we_q, fb_we_d;
  logic [ADDR_W:0]   fb_addr_q, fb_addr_d;
  pixel_t            fb_wdata_q, fb_wdata_d;
  logic              swap_req_q, swap_req_d;
  logic              front_q, front_d;
  logic              overrun_q, overrun_d;
  logic              pending_q, pending_d;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    fb_we_d    = 1'b0;
    fb_addr_d  = fb_addr_q;
    fb_wdata_d = fb_wdata_q;
    swap_req_d = swap_req_q;
    front_d    = front_q;
    overrun_d  = overrun_q;
    pending_d  = pending_q;

    case (state_q)
      ST_IDLE, ST_SKIP, ST_RECEIVE: begin
        if (frame_start) begin
          // a word coinciding with the frame start is the one SKIP would drop
          state_d   = word_evt ? ST_RECEIVE : ST_SKIP;
          count_d   = '0;
          overrun_d = 1'b0;
        end else if (word_evt && state_q == ST_SKIP) begin
          state_d = ST_RECEIVE;
        end else if (word_evt && state_q == ST_RECEIVE) begin
          fb_we_d    = 1'b1;
          fb_addr_d  = {~front_q, count_q};
          fb_wdata_d = pixel_data;
          if (count_q == ADDR_W'(NPIX - 1)) begin
            count_d    = '0;
            state_d    = ST_SWAP;
            swap_req_d = 1'b1;
          end else begin
            count_d = count_q + ADDR_W'(1);
          end
        end
      end
      ST_SWAP: begin
        if (frame_start) begin
          pending_d = 1'b1;
          overrun_d = 1'b0;
        end else if (word_evt) begin
          overrun_d = 1'b1;
        end
        if (swap_ack) begin
          front_d    = ~front_q;
          swap_req_d = 1'b0;
          pending_d  = 1'b0;
          state_d    = (pending_q || frame_start) ? ST_SKIP : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      fb_we_q    <= 1'b0;
      fb_addr_q  <= '0;
      fb_wdata_q <= '0;
      swap_req_q <= 1'b0;
      front_q    <= 1'b0;
      overrun_q  <= 1'b0;
      pending_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      fb_we_q    <= fb_we_d;
      fb_addr_q  <= fb_addr_d;
      fb_wdata_q <= fb_wdata_d;
      swap_req_q <= swap_req_d;
      front_q    <= front_d;
      overrun_q  <= overrun_d;
      pending_q  <= pending_d;
    end
  end

  assign fb_we        = fb_we_q;
  assign fb_addr      = fb_addr_q;
  assign fb_wdata     = fb_wdata_q;
  assign swap_req     = swap_req_q;
  assign front_buffer = front_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_pixel_writer.sv
// Directed bench for pixel_writer: SPI words are driven asynchronously to clk,
// expected framebuffer writes are queued and matched as fb_we pulses appear.
module tb_pixel_writer;

  import pixel_writer_pkg::*;

  localparam int unsigned NPIX = PANEL_W * PANEL_H;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              pixel_clk;
  logic [15:0]       pixel_data;
  logic              spi_ss_n;
  logic              fb_we;
  logic [ADDR_W:0]   fb_addr;
  logic [15:0]       fb_wdata;
  logic              swap_req;
  logic              swap_ack;
  logic              front_buffer;
  logic              overrun;

  pixel_writer #(
    .PANEL_W (PANEL_W),
    .PANEL_H (PANEL_H),
    .ADDR_W  (ADDR_W)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pixel_clk    (pixel_clk),
    .pixel_data   (pixel_data),
    .spi_ss_n     (spi_ss_n),
    .fb_we        (fb_we),
    .fb_addr      (fb_addr),
    .fb_wdata     (fb_wdata),
    .swap_req     (swap_req),
    .swap_ack     (swap_ack),
    .front_buffer (front_buffer),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_count = 0;

  logic [ADDR_W+16:0] exp_q[$];
  logic [ADDR_W+16:0] mon_e;
  logic [15:0]        tx_prev;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every write strobe must match the oldest queued entry
  always @(negedge clk) begin
    if (fb_we === 1'b1) begin
      wr_count++;
      check("wr_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(fb_addr), 32'(mon_e[ADDR_W+16:16]));
        check("wr_data", 32'(fb_wdata), 32'(mon_e[15:0]));
      end
    end
  end

  // One SPI word: the falling strobe carries the previously completed word
  task automatic send_word(input logic [15:0] w, input bit expect_wr, input logic [ADDR_W:0] addr);
    pixel_data = tx_prev;
    pixel_clk  = 1'b1;
    #27;
    if (expect_wr) exp_q.push_back({addr, tx_prev});
    pixel_clk = 1'b0;
    #43;
    tx_prev = w;
  endtask

  task automatic send_frame(input int unsigned n, input logic [15:0] xv, input logic bb, input bit pad);
    for (int unsigned i = 0; i < n; i++) begin
      send_word(16'(i) ^ xv, i >= 1, {bb, ADDR_W'(i - 1)});
    end
    if (pad) send_word(16'hFFFF, 1'b1, {bb, ADDR_W'(n - 1)});
  endtask

  task automatic frame_start();
    spi_ss_n = 1'b1;
    #37;
    spi_ss_n = 1'b0;
    #41;
  endtask

  task automatic ack_pulse();
    @(negedge clk);
    swap_ack = 1'b1;
    @(negedge clk);
    swap_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"},      32'(fb_we),        32'd0);
    check({tag, "_addr"},    32'(fb_addr),      32'd0);
    check({tag, "_wdata"},   32'(fb_wdata),     32'd0);
    check({tag, "_swapreq"}, 32'(swap_req),     32'd0);
    check({tag, "_front"},   32'(front_buffer), 32'd0);
    check({tag, "_overrun"}, 32'(overrun),      32'd0);
  endtask

  initial begin
    reset_n    = 1'b0;
    pixel_clk  = 1'b1;
    spi_ss_n   = 1'b1;
    swap_ack   = 1'b0;
    pixel_data = '0;
    tx_prev    = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // swap_ack while idle is ignored
    ack_pulse();
    check("idle_ack_front", 32'(front_buffer), 32'd0);
    check("idle_ack_swapreq", 32'(swap_req), 32'd0);

    // Full frame: words 0..2047 plus pad into back buffer 1
    frame_start();
    send_frame(NPIX, 16'h0000, 1'b1, 1'b1);
    repeat (10) @(negedge clk);
    check("f0_drained", 32'(exp_q.size()), 32'd0);
    check("f0_writes", 32'(wr_count), 32'(NPIX));
    check("f0_swapreq", 32'(swap_req), 32'd1);
    check("f0_front", 32'(front_buffer), 32'd0);
    check("f0_overrun", 32'(overrun), 32'd0);

    // Words during SWAP are dropped and flag overrun
    for (int i = 0; i < 3; i++) send_word(16'h1234 + 16'(i), 1'b0, '0);
    repeat (5) @(negedge clk);
    check("ovr_writes", 32'(wr_count), 32'(NPIX));
    check("ovr_flag", 32'(overrun), 32'd1);
    check("ovr_swapreq", 32'(swap_req), 32'd1);

    // Frame start during SWAP is held pending; swap_req stays up
    frame_start();
    repeat (3) @(negedge clk);
    check("pend_swapreq", 32'(swap_req), 32'd1);
    check("pend_front", 32'(front_buffer), 32'd0);
    swap_ack = 1'b1;
    #1;
    check("ack_cycle_swapreq", 32'(swap_req), 32'd1);
    @(negedge clk);
    swap_ack = 1'b0;
    check("ack_swapreq_drop", 32'(swap_req), 32'd0);
    check("ack_front", 32'(front_buffer), 32'd1);
    check("ack_overrun_clr", 32'(overrun), 32'd0);

    // Pending start leads straight to SKIP: partial frame into buffer 0
    send_frame(100, 16'h8000, 1'b0, 1'b0);
    ack_pulse();
    check("rx_ack_front", 32'(front_buffer), 32'd1);
    repeat (10) @(negedge clk);
    check("part_drained", 32'(exp_q.size()), 32'd0);
    check("part_writes", 32'(wr_count), 32'(NPIX + 99));
    check("part_swapreq", 32'(swap_req), 32'd0);

    // Abandon partial frame; next frame restarts at address 0, same buffer
    frame_start();
    check("abort_swapreq", 32'(swap_req), 32'd0);
    send_frame(NPIX, 16'h5A5A, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    check("f1_drained", 32'(exp_q.size()), 32'd0);
    check("f1_writes", 32'(wr_count), 32'(2 * NPIX + 99));
    check("f1_swapreq", 32'(swap_req), 32'd1);
    check("f1_front", 32'(front_buffer), 32'd1);
    check("f1_overrun", 32'(overrun), 32'd0);

    ack_pulse();
    check("f1_ack_front", 32'(front_buffer), 32'd0);
    check("f1_ack_swapreq", 32'(swap_req), 32'd0);
    ack_pulse();
    check("idle2_ack_front", 32'(front_buffer), 32'd0);

    // Reset in the middle of a frame
    frame_start();
    send_frame(20, 16'h0F00, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    check("pre_rst_drained", 32'(exp_q.size()), 32'd0);
    check("pre_rst_addr", 32'(fb_addr), 32'({1'b1, ADDR_W'(18)}));
    #3;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    pixel_clk = 1'b1;
    spi_ss_n  = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) send_word(16'h7000 + 16'(i), 1'b0, '0);
    repeat (10) @(negedge clk);
    check("post_rst_writes", 32'(wr_count), 32'(2 * NPIX + 99 + 19));
    check("post_rst_drained", 32'(exp_q.size()), 32'd0);
    check_reset_outputs("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_writer.md
PIXEL_WRITER -- requirements
Module: pixel_writer

Interface
REQ-001 Parameter PANEL_W, default 64, pixels per row.
REQ-002 Parameter PANEL_H, default 32, rows per panel.
REQ-003 Parameter ADDR_W, default 11, pixel address width; SHALL equal log2(PANEL_W*PANEL_H).
REQ-004 clk  input  1  single system clock; all outputs are synchronous to its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 pixel_clk  input  1  word strobe from the SPI receive stage, asynchronous to clk; high for bits 0-7 of each word, low for bits 8-15.
REQ-007 pixel_data  input  16  last completed SPI word; quasi-static while pixel_clk is low.
REQ-008 spi_ss_n  input  1  host frame select, asynchronous; a falling edge marks frame start.
REQ-009 fb_we  output  1  framebuffer write strobe, one clk wide.
REQ-010 fb_addr  output  ADDR_W+1  write address; the MSB is the back-buffer select.
REQ-011 fb_wdata  output  16  pixel word to write.
REQ-012 swap_req  output  1  frame complete; the write side requests a buffer swap.
REQ-013 swap_ack  input  1  the scanner accepts the swap at its vblank; synchronous to clk, one-cycle pulse.
REQ-014 front_buffer  output  1  buffer currently being displayed.
REQ-015 overrun  output  1  sticky error: a word arrived while a swap was pending.

Function
REQ-016 pixel_clk and spi_ss_n SHALL each pass through a 2-flop synchroniser, then a third flop used for edge detection.
REQ-017 A word event SHALL be the synchronised falling edge of pixel_clk.
- pixel_data SHALL be sampled in the clk cycle the event is detected.
- This requires the clk frequency to be at least the spi_clk frequency.
REQ-018 Each word event carries the word completed before the current one. Consequences:
- The first event after a frame start SHALL be discarded.
- The host appends one pad word after each frame.
REQ-019 FSM states and transitions:
- IDLE: on frame start, go to SKIP.
- SKIP: on the next word event, discard the word and go to RECEIVE.
- RECEIVE: on each word event, write one pixel.
- SWAP: hold swap_req high until swap_ack.
REQ-020 In RECEIVE, each word event SHALL produce exactly one fb_we pulse one clk after detection.
- fb_wdata SHALL be the sampled word.
- fb_addr SHALL be {~front_buffer, pixel_count}.
REQ-021 pixel_count SHALL start at 0 and increment after each write.
- The write at PANEL_W*PANEL_H-1 SHALL move the FSM to SWAP.
- pixel_count SHALL then return to 0; it never wraps silently.
REQ-022 In SWAP, swap_req SHALL be 1.
- On swap_ack, front_buffer SHALL toggle and swap_req SHALL drop in the next cycle.
- The FSM SHALL then go to IDLE, or to SKIP if a frame start is pending.
REQ-023 A frame start seen during RECEIVE or SKIP SHALL reset pixel_count to 0 and go to SKIP.
- The partial frame is abandoned and no swap occurs.
REQ-024 A frame start seen during SWAP SHALL be latched as pending; swap_req SHALL remain asserted.
REQ-025 A word event seen during SWAP SHALL be dropped (no fb_we) and SHALL set overrun.
- overrun SHALL clear only on reset or on the next frame start.
REQ-026 swap_ack outside SWAP SHALL be ignored.
REQ-027 Word events in IDLE SHALL be ignored and SHALL NOT set overrun.
REQ-028 A frame start and a word event in the same cycle: the frame start wins, and the word is treated as the discarded SKIP word.

Reset
REQ-029 On reset_n low, all registers SHALL clear immediately:
- FSM = IDLE, pixel_count = 0.
- fb_we = 0, fb_addr = 0, fb_wdata = 0.
- swap_req = 0, front_buffer = 0, overrun = 0, pending = 0.
- Synchroniser flops: pixel_clk stages to 1, spi_ss_n stages to 1.
REQ-030 Reset in mid-frame SHALL abandon the frame; no fb_we SHALL be issued until a new frame start has been followed by SKIP.

Structure
REQ-031 The shared package SHALL hold PANEL_W, PANEL_H, ADDR_W, the 16-bit pixel type and the FSM state enum.
REQ-032 The synchroniser plus edge detector SHALL be one sub-module, edge_sync, instantiated twice (pixel_clk falling, spi_ss_n falling).

Verification
REQ-033 Reset, ss_n fall, 2049 words (word k = k, pad = 0xFFFF) -> 2048 fb_we pulses with addr {1,k} and data k; swap_req=1; no write of 0xFFFF.
REQ-034 In SWAP, send 3 more words, then swap_ack -> no fb_we, overrun=1, front_buffer 0->1, swap_req=0 next cycle.
REQ-035 Frame start after 100 words of a frame -> pixel_count reset; next frame writes from addr 0 into the same back buffer; swap_req stays 0.
REQ-036 ss_n fall during SWAP, then swap_ack -> FSM enters SKIP directly; the next frame writes to buffer 0; overrun clears.
REQ-037 reset_n low mid-RECEIVE, released, words sent without ss_n -> zero fb_we pulses; all outputs at reset values.
REQ-038 swap_ack pulse in IDLE and in RECEIVE -> front_buffer unchanged.
